// File: rtl/seq_booth_multiplier_32_bit.sv
// Sequential radix-4 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product,
// one recoded bit-pair per clock behind a start/busy/done handshake.
module seq_booth_multiplier_32_bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   c
);

    localparam int unsigned AW    = WIDTH + 2;
    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_m;
    logic [WIDTH-1:0]  r_q;
    logic              r_q_m1;
    logic [AW-1:0]     r_acc;
    logic [CW-1:0]     r_cnt;

    logic [AW-1:0]          w_m1;
    logic [AW-1:0]          w_m2;
    logic [AW-1:0]          w_term;
    logic [AW-1:0]          w_sum;
    logic signed [AW+WIDTH:0] w_cat;
    logic [AW+WIDTH:0]      w_shift;

    // Two guard bits keep -2M exact even for M = -2^(WIDTH-1).
    assign w_m1 = {{2{r_m[WIDTH-1]}}, r_m};
    assign w_m2 = {r_m[WIDTH-1], r_m, 1'b0};

    always_comb begin
        w_term = '0;
        case ({r_q[1:0], r_q_m1})
            3'b001, 3'b010: w_term = w_m1;
            3'b011:         w_term = w_m2;
            3'b100:         w_term = -w_m2;
            3'b101, 3'b110: w_term = -w_m1;
            default:        w_term = '0;
        endcase
    end

    assign w_sum   = r_acc + w_term;
    assign w_cat   = {w_sum, r_q, r_q_m1};
    assign w_shift = w_cat >>> 2;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_q_m1  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            c       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_q_m1  <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_shift[AW+WIDTH:WIDTH+1];
                    r_q    <= w_shift[WIDTH:1];
                    r_q_m1 <= w_shift[0];
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        c       <= w_shift[2*WIDTH:1];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier_32_bit.sv
// Directed and random checks of the sequential Booth multiplier against
// hand-computed products and a signed 64-bit reference.
module tb_seq_booth_multiplier_32_bit;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] c;

    int checks   = 0;
    int failures = 0;

    seq_booth_multiplier_32_bit #(.WIDTH(32)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .c            (c)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] m, input logic [31:0] q);
        @(negedge clock);
        mcand  = m;
        mplier = q;
        start  = 1'b1;
        @(posedge clock);
        #1;
        check("accept_busy", 64'(busy), 64'd1);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts rising edges until done is seen, bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clock);
            n++;
            #1;
        end while (!done && n < 40);
    endtask

    task automatic mul(input string tag, input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] exp);
        int n;
        start_op(m, q);
        wait_done(n);
        check({tag, "_lat"},  64'(n), 64'd16);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_c"},    c, exp);
        @(posedge clock);
        #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;
        longint      ref_p;

        clear  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;

        #12;
        clear = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_c", c, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_c", c, 64'd0);

        mul("basic",  32'hFFFF_FFF9, 32'd3,        64'hFFFF_FFFF_FFFF_FFEB);
        mul("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        mul("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        mul("m1m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        mul("zero",   32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000);
        mul("p16",    32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        mul("minone", 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
        mul("minmax", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);

        // start during RUN and during DONE with altered operands must be ignored
        start_op(32'hFFFF_FFF9, 32'd3);
        repeat (5) @(posedge clock);
        @(negedge clock);
        mcand  = 32'd100;
        mplier = 32'd200;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(n);
        check("hs_lat", 64'(n), 64'd10);
        check("hs_c", c, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        check("hs_done_ign", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        check("hs_idle_busy", 64'(busy), 64'd0);
        check("hs_c_hold", c, 64'hFFFF_FFFF_FFFF_FFEB);

        // start held high: one result every 18 cycles
        @(negedge clock);
        mcand  = 32'd5;
        mplier = 32'hFFFF_FFFA;
        start  = 1'b1;
        @(posedge clock);
        wait_done(n);
        check("b2b_lat0", 64'(n), 64'd16);
        check("b2b_c0", c, 64'hFFFF_FFFF_FFFF_FFE2);
        for (int k = 0; k < 2; k++) begin
            wait_done(n);
            check("b2b_period", 64'(n), 64'd18);
            check("b2b_c", c, 64'hFFFF_FFFF_FFFF_FFE2);
        end
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("b2b_stop", 64'(busy), 64'd0);

        // abort in the middle of RUN
        start_op(32'h1234_5678, 32'd3);
        repeat (8) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_c", c, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clock);
            #1;
            if (done || busy) seen++;
        end
        check("abort_quiet", 64'(seen), 64'd0);
        mul("after_abort", 32'd5, 32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFE2);

        for (int k = 0; k < 2000; k++) begin
            ra    = $urandom;
            rb    = $urandom;
            ref_p = longint'($signed(ra)) * longint'($signed(rb));
            mul("rand", ra, rb, ref_p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
